// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM window controller: FSM encoding and default widths.
package sram_ctrl_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      PRESENT = 2'd3
   } state_t;

endpackage

// File: rtl/sram_window_ctrl_if.sv
// Sample input, window readout and SRAM port bundle for sram_window_ctrl.
interface sram_window_ctrl_if #(
   parameter int ADDR_W = sram_ctrl_pkg::ADDR_W_DEF,
   parameter int DATA_W = sram_ctrl_pkg::DATA_W_DEF
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              rd_start;
   logic [ADDR_W:0]   rd_len;
   logic              rd_err;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              sram_cs;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_a;
   logic [DATA_W-1:0] sram_d;
   logic [DATA_W-1:0] sram_q;

   // controller side
   modport slave (
      input  in_valid, in_data, rd_start, rd_len, out_ready, sram_q,
      output in_ready, rd_err, busy, out_valid, out_data, out_last,
             sram_cs, sram_we, sram_a, sram_d
   );

   // producer / consumer / SRAM side
   modport master (
      output in_valid, in_data, rd_start, rd_len, out_ready, sram_q,
      input  in_ready, rd_err, busy, out_valid, out_data, out_last,
             sram_cs, sram_we, sram_a, sram_d
   );

endinterface

// File: rtl/sram_window_ctrl.sv
// Circular sample buffer in an external 1RW SRAM; streams the most recent
// rd_len samples, oldest first, one word per ISSUE/CAPTURE/PRESENT round.
module sram_window_ctrl #(
   parameter int ADDR_W = sram_ctrl_pkg::ADDR_W_DEF,
   parameter int DATA_W = sram_ctrl_pkg::DATA_W_DEF
) (
   input  logic              CK,
   input  logic              RST,
   sram_window_ctrl_if.slave bus
);
   import sram_ctrl_pkg::*;

   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] wptr_reg, rptr_reg;
   logic [ADDR_W:0]   count_reg, remaining_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_last_reg;
   logic              rd_err_reg;

   logic idle, len_ok, rd_accept, rd_reject, wr_fire;

   always_comb begin
      idle      = (state_reg == IDLE);
      len_ok    = (bus.rd_len != '0) && (bus.rd_len <= count_reg);
      rd_accept = idle && bus.rd_start && len_ok;
      rd_reject = idle && bus.rd_start && !len_ok;
      // a read request in the same cycle takes priority over the sample
      wr_fire   = idle && !bus.rd_start && !RST && bus.in_valid;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (rd_accept) state_next = ISSUE;
         ISSUE:   state_next = CAPTURE;
         CAPTURE: state_next = PRESENT;
         PRESENT: if (bus.out_ready) state_next = out_last_reg ? IDLE : ISSUE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = idle && !bus.rd_start && !RST;
      bus.sram_cs  = 1'b0;
      bus.sram_we  = 1'b0;
      bus.sram_a   = '0;
      bus.sram_d   = '0;
      if (wr_fire) begin
         bus.sram_cs = 1'b1;
         bus.sram_we = 1'b1;
         bus.sram_a  = wptr_reg;
         bus.sram_d  = bus.in_data;
      end else if (state_reg == ISSUE) begin
         bus.sram_cs = 1'b1;
         bus.sram_a  = rptr_reg;
      end
   end

   assign bus.busy      = !idle;
   assign bus.out_valid = (state_reg == PRESENT);
   assign bus.out_data  = out_data_reg;
   assign bus.out_last  = out_last_reg;
   assign bus.rd_err    = rd_err_reg;

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_reg     <= IDLE;
         wptr_reg      <= '0;
         count_reg     <= '0;
         rptr_reg      <= '0;
         remaining_reg <= '0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         rd_err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rd_err_reg <= rd_reject;
         if (wr_fire) begin
            wptr_reg <= wptr_reg + PTR_ONE;
            if (count_reg != COUNT_MAX) count_reg <= count_reg + CNT_ONE;
         end
         // rd_len == DEPTH truncates to 0, so the window starts at wptr itself
         if (rd_accept) begin
            rptr_reg      <= wptr_reg - bus.rd_len[ADDR_W-1:0];
            remaining_reg <= bus.rd_len;
         end
         if (state_reg == CAPTURE) begin
            out_data_reg  <= bus.sram_q;
            out_last_reg  <= (remaining_reg == CNT_ONE);
            rptr_reg      <= rptr_reg + PTR_ONE;
            remaining_reg <= remaining_reg - CNT_ONE;
         end
      end
   end

endmodule
